// File: rtl/receive_pixel_if.sv
// Pixel stream toward image BRAM: 12-bit pixel with linear address and valid/ready handshake.
interface receive_pixel_if;
    logic [11:0] pixel;
    logic [16:0] pixel_addr;
    logic        valid_out;
    logic        ready_in;

    modport master (output pixel, output pixel_addr, output valid_out, input ready_in);
    modport slave  (input pixel, input pixel_addr, input valid_out, output ready_in);
endinterface

// File: rtl/receive_pixel.sv
// UART receiver that pairs bytes into 12-bit pixels and streams one armed frame of IMAGE_SIZE
// pixels with addresses. BITS_N is expected to be at least 8; the pixel uses the low 8 data bits.
module receive_pixel #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int BITS_N       = 8,
    parameter int PARITY_TYPE  = 0,
    parameter int IMAGE_SIZE   = 2500
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_uart_in,
    input  logic i_start,
    receive_pixel_if.master px,
    output logic o_busy,
    output logic o_frame_done,
    output logic o_rx_error,
    output logic o_overrun
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (BITS_N > 2) ? $clog2(BITS_N) : 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BITS_N - 1);
    localparam logic [16:0]      LAST_IDX = 17'(IMAGE_SIZE - 1);

    typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_PARITY, B_STOP} bit_state_t;
    typedef enum logic [1:0] {F_IDLE, F_RECV, F_DONE} frame_state_t;

    // line synchroniser; r_rx_d is one extra stage used only for edge detection
    logic r_sync1, r_rx, r_rx_d;
    logic w_fall;

    bit_state_t        r_bit_state, w_bit_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [BIT_W-1:0]  r_bit_idx, w_bit_idx_next;
    logic [BITS_N-1:0] r_shift, w_shift_next;
    logic              r_par_err, w_par_err_next;
    logic              w_par_exp;
    logic              w_byte_ok, w_byte_bad;
    logic [7:0]        w_byte;

    frame_state_t r_frame, w_frame_next;
    logic         w_load, w_fd_next;
    logic         r_phase_high;
    logic [7:0]   r_pix_hi;
    logic [16:0]  r_index;
    logic [11:0]  r_pixel;
    logic [16:0]  r_addr;
    logic         r_valid;
    logic         r_frame_done, r_rx_error, r_overrun;
    logic         w_ready;

    assign w_ready = px.ready_in;
    assign w_fall  = r_rx_d & ~r_rx;
    assign w_byte  = r_shift[7:0];
    assign w_par_exp = (PARITY_TYPE == 1) ? ~(^r_shift) : (^r_shift);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_rx    <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= i_uart_in;
            r_rx    <= r_sync1;
            r_rx_d  <= r_rx;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bit_state <= B_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
        end else begin
            r_bit_state <= w_bit_next;
            r_cnt       <= w_cnt_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shift     <= w_shift_next;
            r_par_err   <= w_par_err_next;
        end
    end

    always_comb begin
        w_bit_next     = r_bit_state;
        w_cnt_next     = r_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_par_err_next = r_par_err;
        w_byte_ok      = 1'b0;
        w_byte_bad     = 1'b0;
        case (r_bit_state)
            B_IDLE: begin
                if (w_fall) begin
                    w_bit_next = B_START;
                    w_cnt_next = HALF_CNT;
                end
            end
            B_START: begin
                if (r_cnt == '0) begin
                    if (!r_rx) begin
                        w_bit_next     = B_DATA;
                        w_cnt_next     = FULL_CNT;
                        w_bit_idx_next = LAST_BIT;
                        w_par_err_next = 1'b0;
                    end else begin
                        w_bit_next = B_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            B_DATA: begin
                if (r_cnt == '0) begin
                    w_shift_next = {r_rx, r_shift[BITS_N-1:1]};
                    w_cnt_next   = FULL_CNT;
                    if (r_bit_idx == '0) begin
                        w_bit_next = (PARITY_TYPE != 0) ? B_PARITY : B_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx - 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            B_PARITY: begin
                if (r_cnt == '0) begin
                    w_par_err_next = (r_rx != w_par_exp);
                    w_cnt_next     = FULL_CNT;
                    w_bit_next     = B_STOP;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            B_STOP: begin
                if (r_cnt == '0) begin
                    w_bit_next = B_IDLE;
                    if (r_rx && !r_par_err) w_byte_ok  = 1'b1;
                    else                    w_byte_bad = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: w_bit_next = B_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_frame <= F_IDLE;
        else       r_frame <= w_frame_next;
    end

    always_comb begin
        w_frame_next = r_frame;
        w_load       = 1'b0;
        w_fd_next    = 1'b0;
        case (r_frame)
            F_IDLE: begin
                if (i_start) w_frame_next = F_RECV;
            end
            F_RECV: begin
                if (w_byte_ok && !r_phase_high) begin
                    w_load = 1'b1;
                    if (r_index == LAST_IDX) w_frame_next = F_DONE;
                end
            end
            F_DONE: begin
                if (!r_valid || w_ready) begin
                    w_frame_next = F_IDLE;
                    w_fd_next    = 1'b1;
                end
            end
            default: w_frame_next = F_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase_high <= 1'b1;
            r_pix_hi     <= '0;
            r_index      <= '0;
            r_pixel      <= '0;
            r_addr       <= '0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_rx_error   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_done <= w_fd_next;
            if (r_frame == F_IDLE && i_start) begin
                r_index      <= '0;
                r_rx_error   <= 1'b0;
                r_overrun    <= 1'b0;
                r_phase_high <= 1'b1;
            end else if (r_frame == F_RECV) begin
                if (w_byte_bad) begin
                    // a corrupted byte resynchronises on the next pixel boundary
                    r_rx_error   <= 1'b1;
                    r_phase_high <= 1'b1;
                end else if (w_byte_ok) begin
                    if (r_phase_high) r_pix_hi <= w_byte;
                    r_phase_high <= ~r_phase_high;
                end
            end

            if (w_load) begin
                r_pixel <= {r_pix_hi, w_byte[3:0]};
                r_addr  <= r_index;
                r_valid <= 1'b1;
                r_index <= r_index + 17'd1;
                if (r_valid && !w_ready) r_overrun <= 1'b1;
            end else if (r_valid && w_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign px.pixel      = r_pixel;
    assign px.pixel_addr = r_addr;
    assign px.valid_out  = r_valid;
    assign o_busy        = (r_frame != F_IDLE);
    assign o_frame_done  = r_frame_done;
    assign o_rx_error    = r_rx_error;
    assign o_overrun     = r_overrun;

endmodule
